// File: rtl/stream_extrema_tracker.sv
`default_nettype none
// ============================================================================
// Module      : stream_extrema_tracker
// Description : Tracks per-frame maximum and minimum of a valid/ready sample
//               stream, with the index of the first occurrence of each, and
//               emits one registered result record per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_extrema_tracker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int SIGNED    = 0,
    localparam int c_IW     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [c_IW-1:0]  out_max_idx,
    output logic [c_IW-1:0]  out_min_idx,
    output logic [c_IW:0]    out_count
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_ACCUM = 2'd1;
    localparam logic [1:0]  S_HOLD  = 2'd2;
    localparam logic [c_IW:0] c_FULL = (c_IW + 1)'(FRAME_LEN);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [c_IW-1:0]  r_max_idx;
    logic [c_IW-1:0]  r_min_idx;
    logic [c_IW:0]    r_count;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_max;
    logic [WIDTH-1:0] r_out_min;
    logic [c_IW-1:0]  r_out_max_idx;
    logic [c_IW-1:0]  r_out_min_idx;
    logic [c_IW:0]    r_out_count;

    logic             w_accept;
    logic             w_gt;
    logic             w_lt;
    logic             w_close;
    logic [WIDTH-1:0] w_nxt_max;
    logic [WIDTH-1:0] w_nxt_min;
    logic [c_IW-1:0]  w_nxt_max_idx;
    logic [c_IW-1:0]  w_nxt_min_idx;
    logic [c_IW:0]    w_nxt_count;

    // No samples are taken while a record is pending or during reset.
    assign in_ready = !rst && !r_out_valid;
    assign w_accept = in_valid && in_ready;

    // Strict comparisons against the running extrema; ties keep the first index.
    if (SIGNED != 0) begin : g_signed
        assign w_gt = $signed(in_data) > $signed(r_max);
        assign w_lt = $signed(in_data) < $signed(r_min);
    end else begin : g_unsigned
        assign w_gt = in_data > r_max;
        assign w_lt = in_data < r_min;
    end

    // Accumulator values including the current sample when one is accepted.
    always_comb begin
        w_nxt_max     = r_max;
        w_nxt_min     = r_min;
        w_nxt_max_idx = r_max_idx;
        w_nxt_min_idx = r_min_idx;
        w_nxt_count   = r_count;
        if (w_accept) begin
            if (r_state == S_IDLE) begin
                w_nxt_max     = in_data;
                w_nxt_min     = in_data;
                w_nxt_max_idx = '0;
                w_nxt_min_idx = '0;
                w_nxt_count   = (c_IW + 1)'(1);
            end else begin
                if (w_gt) begin
                    w_nxt_max     = in_data;
                    w_nxt_max_idx = r_count[c_IW-1:0];
                end
                if (w_lt) begin
                    w_nxt_min     = in_data;
                    w_nxt_min_idx = r_count[c_IW-1:0];
                end
                w_nxt_count = r_count + 1'b1;
            end
        end
    end

    // A frame closes on last sample, full frame, or flush with data present.
    assign w_close = (w_accept && (in_last || (w_nxt_count == c_FULL))) ||
                     (flush && ((r_state == S_ACCUM) || w_accept));

    // Frame state machine: accumulate, latch the record, hold until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_max         <= '0;
            r_min         <= '0;
            r_max_idx     <= '0;
            r_min_idx     <= '0;
            r_count       <= '0;
            r_out_valid   <= 1'b0;
            r_out_max     <= '0;
            r_out_min     <= '0;
            r_out_max_idx <= '0;
            r_out_min_idx <= '0;
            r_out_count   <= '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    if (w_close) begin
                        r_out_max     <= w_nxt_max;
                        r_out_min     <= w_nxt_min;
                        r_out_max_idx <= w_nxt_max_idx;
                        r_out_min_idx <= w_nxt_min_idx;
                        r_out_count   <= w_nxt_count;
                        r_out_valid   <= 1'b1;
                        r_count       <= '0;
                        r_state       <= S_HOLD;
                    end else if (w_accept) begin
                        r_max     <= w_nxt_max;
                        r_min     <= w_nxt_min;
                        r_max_idx <= w_nxt_max_idx;
                        r_min_idx <= w_nxt_min_idx;
                        r_count   <= w_nxt_count;
                        r_state   <= S_ACCUM;
                    end
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_max     = r_out_max;
    assign out_min     = r_out_min;
    assign out_max_idx = r_out_max_idx;
    assign out_min_idx = r_out_min_idx;
    assign out_count   = r_out_count;

endmodule
`default_nettype wire

// File: tb/tb_stream_extrema_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_extrema_tracker
// Description : Directed self-checking bench for stream_extrema_tracker,
//               one unsigned and one signed instance on shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_extrema_tracker;

    localparam int c_W  = 8;
    localparam int c_FL = 4;
    localparam int c_IW = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [c_W-1:0]   in_data;
    logic             in_last;
    logic             flush;
    logic             out_ready;

    logic             u_in_ready, u_out_valid;
    logic [c_W-1:0]   u_max, u_min;
    logic [c_IW-1:0]  u_max_idx, u_min_idx;
    logic [c_IW:0]    u_count;

    logic             s_in_ready, s_out_valid;
    logic [c_W-1:0]   s_max, s_min;
    logic [c_IW-1:0]  s_max_idx, s_min_idx;
    logic [c_IW:0]    s_count;

    int n_checks = 0;
    int n_errors = 0;

    stream_extrema_tracker #(.WIDTH(c_W), .FRAME_LEN(c_FL), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_last(in_last), .flush(flush),
        .out_valid(u_out_valid), .out_ready(out_ready),
        .out_max(u_max), .out_min(u_min), .out_max_idx(u_max_idx),
        .out_min_idx(u_min_idx), .out_count(u_count)
    );

    stream_extrema_tracker #(.WIDTH(c_W), .FRAME_LEN(c_FL), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_max(s_max), .out_min(s_min), .out_max_idx(s_max_idx),
        .out_min_idx(s_min_idx), .out_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until the unsigned instance accepts it.
    task automatic send(input logic [7:0] d, input logic last, input logic fl);
        int waited;
        waited = 0;
        while (!u_in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!u_in_ready) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic take(input string tag);
        check({tag, "_ov"}, 32'(u_out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(u_out_valid), 32'd0);
        check({tag, "_ir_back"}, 32'(u_in_ready), 32'd1);
    endtask

    task automatic expect_rec(input string tag, input logic [7:0] mx, input int mxi,
                              input logic [7:0] mn, input int mni, input int cnt);
        check({tag, "_max"},     32'(u_max),     32'(mx));
        check({tag, "_max_idx"}, 32'(u_max_idx), 32'(mxi));
        check({tag, "_min"},     32'(u_min),     32'(mn));
        check({tag, "_min_idx"}, 32'(u_min_idx), 32'(mni));
        check({tag, "_count"},   32'(u_count),   32'(cnt));
    endtask

    initial begin
        logic [7:0] held_max;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(u_in_ready), 32'd0);
        check("rst_ov",    32'(u_out_valid), 32'd0);
        check("rst_max",   32'(u_max), 32'd0);
        check("rst_count", 32'(u_count), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(u_in_ready), 32'd1);

        // Full frame closes on the FRAME_LEN-th sample.
        send(8'd3, 1'b0, 1'b0);
        send(8'd9, 1'b0, 1'b0);
        send(8'd9, 1'b0, 1'b0);
        check("full_ov_early", 32'(u_out_valid), 32'd0);
        send(8'd1, 1'b0, 1'b0);
        expect_rec("full", 8'd9, 1, 8'd1, 3, 4);
        check("full_ready_hold", 32'(u_in_ready), 32'd0);
        take("full");

        // in_last termination.
        send(8'd200, 1'b0, 1'b0);
        send(8'd50, 1'b1, 1'b0);
        expect_rec("last", 8'd200, 0, 8'd50, 1, 2);
        take("last");

        // Single-sample frame.
        send(8'd42, 1'b1, 1'b0);
        expect_rec("single", 8'd42, 0, 8'd42, 0, 1);
        take("single");

        // Signed vs unsigned on the same data.
        send(8'h80, 1'b0, 1'b0);
        send(8'h7F, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        expect_rec("uns", 8'hFF, 2, 8'h00, 3, 4);
        check("sgn_max",     32'(s_max),     32'h7F);
        check("sgn_max_idx", 32'(s_max_idx), 32'd1);
        check("sgn_min",     32'(s_min),     32'h80);
        check("sgn_min_idx", 32'(s_min_idx), 32'd0);
        check("sgn_count",   32'(s_count),   32'd4);

        // Backpressure: record stays put and no sample is taken.
        held_max = u_max;
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_ov",    32'(u_out_valid), 32'd1);
            check("bp_ready", 32'(u_in_ready),  32'd0);
            check("bp_max",   32'(u_max),       32'(held_max));
            check("bp_count", 32'(u_count),     32'd4);
        end
        in_valid = 1'b0;
        take("bp");
        send(8'd4, 1'b0, 1'b0);
        send(8'd4, 1'b0, 1'b0);
        send(8'd4, 1'b0, 1'b0);
        send(8'd4, 1'b0, 1'b0);
        expect_rec("ties", 8'd4, 0, 8'd4, 0, 4);
        take("ties");

        // Flush pulse on a partial frame.
        send(8'd5, 1'b0, 1'b0);
        send(8'd2, 1'b0, 1'b0);
        send(8'd7, 1'b0, 1'b0);
        check("flush_ov_early", 32'(u_out_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_rec("flush", 8'd7, 2, 8'd2, 1, 3);
        take("flush");

        // Flush in IDLE produces nothing.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("idle_flush_ov", 32'(u_out_valid), 32'd0);
        tick();
        check("idle_flush_ov2", 32'(u_out_valid), 32'd0);

        // Flush together with an accepted sample includes that sample.
        send(8'd5, 1'b0, 1'b0);
        send(8'd8, 1'b0, 1'b1);
        expect_rec("flush_acc", 8'd8, 1, 8'd5, 0, 2);
        take("flush_acc");

        // Reset mid-frame discards the partial frame.
        send(8'd10, 1'b0, 1'b0);
        send(8'd20, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(u_in_ready), 32'd0);
        tick();
        check("mid_rst_ov", 32'(u_out_valid), 32'd0);
        rst = 1'b0;
        #1;
        send(8'd4, 1'b0, 1'b0);
        send(8'd4, 1'b0, 1'b0);
        send(8'd4, 1'b0, 1'b0);
        check("mid_rst_ov_early", 32'(u_out_valid), 32'd0);
        send(8'd4, 1'b0, 1'b0);
        expect_rec("after_rst", 8'd4, 0, 8'd4, 0, 4);
        take("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
